uart_imem_loader: RTL

- Boot-time writer for the instruction memory that the fetch stage reads.
- Receives a program image over a UART RX line (8N1) and assembles little-endian 32-bit words.
- Issues one write strobe per word into instruction memory.
- Holds the core (cpu_hold) until the image is loaded.
- Sits beside the fetch stage; its write port drives the same instruction memory that fetch consumes via its uart_data input.

---
 rtl/uart_imem_loader.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_imem_loader.sv
// Boot loader: receives an 8N1 UART image (sync byte, 16-bit word count, little-endian words) and writes it into instruction memory.
// Optional trailing XOR checksum byte is enabled with the macro UART_IMEM_LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int         CLK_FREQ_HZ = 50000000,
  parameter int         BAUD_RATE   = 115200,
  parameter int         ADDR_WIDTH  = 10,
  parameter int         MAX_WORDS   = 1024,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_error,
  output logic                  size_error
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  ,
  output logic                  checksum_error
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF      = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [16:0]      C_MAX_WORDS = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  typedef enum logic [2:0] {
    L_SYNC, L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    , L_CHK
`endif
  } ldState_t;

  rxState_t         r_rxState;
  logic             r_rxMeta;
  logic             r_rxSync;
  logic [CNT_W-1:0] r_clkCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_byteValid;
  logic [7:0]       r_byte;
  logic             r_frameError;

  ldState_t          r_ldState;
  logic [7:0]        r_lenLo;
  logic [ADDR_WIDTH:0] r_lastIdx;
  logic [ADDR_WIDTH:0] r_wordIdx;
  logic [1:0]        r_byteIdx;
  logic [31:0]       r_word;
  logic              r_wrPending;
  logic              r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpuHold;
  logic              r_loadDone;
  logic              r_sizeError;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_csumError;
`endif

  logic [15:0] w_len;
  assign w_len = {r_byte, r_lenLo};

  // UART receiver: start bit re-checked at mid-bit, then data/stop sampled one bit period apart
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxMeta     <= 1'b1;
      r_rxSync     <= 1'b1;
      r_rxState    <= RX_IDLE;
      r_clkCnt     <= '0;
      r_bitIdx     <= '0;
      r_shift      <= '0;
      r_byteValid  <= 1'b0;
      r_byte       <= '0;
      r_frameError <= 1'b0;
    end else begin
      r_rxMeta    <= rx;
      r_rxSync    <= r_rxMeta;
      r_byteValid <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          if (!r_rxSync) begin
            r_rxState <= RX_START;
            r_clkCnt  <= '0;
          end
        end
        RX_START: begin
          if (r_clkCnt == C_HALF) begin
            r_clkCnt  <= '0;
            r_bitIdx  <= '0;
            r_rxState <= r_rxSync ? RX_IDLE : RX_DATA;
          end else begin
            r_clkCnt <= r_clkCnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_clkCnt == C_BIT_LAST) begin
            r_clkCnt <= '0;
            r_shift  <= {r_rxSync, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) r_rxState <= RX_STOP;
          end else begin
            r_clkCnt <= r_clkCnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_clkCnt == C_BIT_LAST) begin
            r_clkCnt  <= '0;
            r_rxState <= RX_IDLE;
            if (r_rxSync) begin
              r_byteValid <= 1'b1;
              r_byte      <= r_shift;
            end else begin
              r_frameError <= 1'b1;
            end
          end else begin
            r_clkCnt <= r_clkCnt + CNT_W'(1);
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  // Loader: header parse, word assembly and one-cycle write strobe the cycle after the 4th byte is latched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ldState   <= L_SYNC;
      r_lenLo     <= '0;
      r_lastIdx   <= '0;
      r_wordIdx   <= '0;
      r_byteIdx   <= '0;
      r_word      <= '0;
      r_wrPending <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpuHold   <= 1'b1;
      r_loadDone  <= 1'b0;
      r_sizeError <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      r_csum      <= '0;
      r_csumError <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_ldState)
        L_SYNC: begin
          if (r_byteValid && r_byte == SYNC_BYTE) r_ldState <= L_LEN0;
        end
        L_LEN0: begin
          if (r_byteValid) begin
            r_lenLo   <= r_byte;
            r_ldState <= L_LEN1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            r_csum    <= r_byte;
`endif
          end
        end
        L_LEN1: begin
          if (r_byteValid) begin
            r_byteIdx <= '0;
            r_wordIdx <= '0;
            r_lastIdx <= (ADDR_WIDTH+1)'(w_len - 16'd1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ r_byte;
`endif
            if (w_len == 16'd0) begin
              r_ldState <= L_DONE;
            end else if ({1'b0, w_len} > C_MAX_WORDS) begin
              r_sizeError <= 1'b1;
              r_ldState   <= L_ERR;
            end else begin
              r_ldState <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (r_wrPending) begin
            r_wrPending <= 1'b0;
            r_we        <= 1'b1;
            r_addr      <= r_wordIdx[ADDR_WIDTH-1:0];
            r_wdata     <= r_word;
            r_wordIdx   <= r_wordIdx + (ADDR_WIDTH+1)'(1);
            if (r_wordIdx == r_lastIdx) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
              r_ldState <= L_CHK;
`else
              r_ldState <= L_DONE;
`endif
            end
          end else if (r_byteValid) begin
            r_word[{r_byteIdx, 3'b000} +: 8] <= r_byte;
            r_byteIdx <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) r_wrPending <= 1'b1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ r_byte;
`endif
          end
        end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        L_CHK: begin
          if (r_byteValid) begin
            if (r_byte == r_csum) begin
              r_ldState <= L_DONE;
            end else begin
              r_csumError <= 1'b1;
              r_ldState   <= L_ERR;
            end
          end
        end
`endif
        L_DONE: begin
          r_loadDone <= 1'b1;
          r_cpuHold  <= 1'b0;
        end
        L_ERR: begin
          r_cpuHold <= 1'b1;
        end
        default: r_ldState <= L_SYNC;
      endcase
    end
  end

  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign cpu_hold    = r_cpuHold;
  assign load_done   = r_loadDone;
  assign frame_error = r_frameError;
  assign size_error  = r_sizeError;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  assign checksum_error = r_csumError;
`endif

endmodule
